branch_target_lut: RTL and testbench

- Small fully-associative lookup table used as a branch target buffer by the branch unit.
- Fetch side presents the current PC each cycle and gets back a predicted target plus a hit flag, combinationally.
- Execute side writes a (branch PC, resolved target) pair when a mispredict flush occurs.

---
 rtl/branch_target_lut_pkg.sv | 25 ++
 rtl/branch_target_lut_match.sv | 42 ++++
 rtl/branch_target_lut.sv | 140 ++++++++++++++
 tb/tb_branch_target_lut.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/branch_target_lut_pkg.sv
// Shared definitions for the branch target lookup table: default sizes,
// pointer-width helper and the write-side action encoding.
package branch_target_lut_pkg;

    // Default key/value width; keys are fetch PCs, values are branch targets.
    localparam int unsigned DEFAULT_ADDR_WIDTH = 16;

    // Default number of entries; must be a power of two, at least 2.
    localparam int unsigned DEFAULT_DEPTH = 8;

    // Width of an entry index / victim pointer for a table of the given depth.
    // Clamped to 1 so a degenerate depth still yields a legal vector width.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // What a write strobe does to the table this cycle.
    typedef enum logic [1:0] {
        WrNone,    // no write, or write suppressed
        WrUpdate,  // key already present: overwrite its value only
        WrFill,    // key absent, free slot available: claim lowest free slot
        WrEvict    // key absent, table full: replace entry at victim pointer
    } wr_action_e;

endpackage

// File: rtl/branch_target_lut_match.sv
// Combinational comparator array: compares one key against every valid
// entry and reports a one-hot hit vector, an any-hit flag and the index of
// the first (lowest-index) matching entry.
module lut_match #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned IDX_WIDTH  = 3
) (
    input  logic [ADDR_WIDTH-1:0]            key,
    input  logic [DEPTH-1:0]                 valid,
    input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] keys,
    output logic [DEPTH-1:0]                 hit_onehot,
    output logic                             any_hit,
    output logic [IDX_WIDTH-1:0]             hit_idx
);

    logic [DEPTH-1:0] raw_hit;

    // Per-entry match; an entry only matches while its valid bit is set.
    always_comb begin
        raw_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            raw_hit[i] = valid[i] && (keys[i] == key);
        end
    end

    // Priority-select the lowest matching index so the hit vector stays
    // one-hot even if duplicate keys ever appear.
    always_comb begin
        hit_onehot = '0;
        any_hit    = 1'b0;
        hit_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raw_hit[i] && !any_hit) begin
                hit_onehot[i] = 1'b1;
                any_hit       = 1'b1;
                hit_idx       = IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/branch_target_lut.sv
// Fully-associative branch target buffer. Fetch reads are combinational;
// execute writes (branch PC, target) pairs on mispredict. Writes update in
// place on a hit, fill the lowest free slot on a miss, and fall back to
// round-robin replacement once the table is full.
module branch_target_lut
    import branch_target_lut_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] write_key,
    input  logic [ADDR_WIDTH-1:0] write_val,
    input  logic [ADDR_WIDTH-1:0] read_key,
    output logic [ADDR_WIDTH-1:0] read_val,
    output logic                  read_valid
);

    localparam int unsigned IDX_WIDTH = ptr_width(DEPTH);

    // Table state.
    logic [DEPTH-1:0]                 valid_q;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] key_q;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] val_q;
    logic [IDX_WIDTH-1:0]             victim_q;

    // Comparator results.
    logic [DEPTH-1:0]     rd_onehot;
    logic                 rd_hit;
    logic [IDX_WIDTH-1:0] rd_idx;
    logic [DEPTH-1:0]     wr_onehot;
    logic                 wr_hit;
    logic [IDX_WIDTH-1:0] wr_hit_idx;

    // Write decision.
    logic                 free_found;
    logic [IDX_WIDTH-1:0] free_idx;
    wr_action_e           wr_action;
    logic [IDX_WIDTH-1:0] wr_idx;

    // Index outputs are used for muxing; the one-hot forms are redundant here.
    logic unused_onehot;
    assign unused_onehot = ^{rd_onehot, wr_onehot};

    lut_match #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_read_match (
        .key        (read_key),
        .valid      (valid_q),
        .keys       (key_q),
        .hit_onehot (rd_onehot),
        .any_hit    (rd_hit),
        .hit_idx    (rd_idx)
    );

    lut_match #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_write_match (
        .key        (write_key),
        .valid      (valid_q),
        .keys       (key_q),
        .hit_onehot (wr_onehot),
        .any_hit    (wr_hit),
        .hit_idx    (wr_hit_idx)
    );

    // Read port: value of the matching entry, forced to zero on a miss so
    // nothing stale leaks out. Driven purely from registered state, so the
    // async reset clears it without a clock.
    always_comb begin
        read_valid = rd_hit;
        read_val   = rd_hit ? val_q[rd_idx] : '0;
    end

    // Lowest-index invalid entry, used when a new key needs a home.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_WIDTH'(i);
            end
        end
    end

    // Pick what a write does and which entry it targets.
    always_comb begin
        wr_action = WrNone;
        wr_idx    = '0;
        if (write) begin
            if (wr_hit) begin
                wr_action = WrUpdate;
                wr_idx    = wr_hit_idx;
            end else if (free_found) begin
                wr_action = WrFill;
                wr_idx    = free_idx;
            end else begin
                wr_action = WrEvict;
                wr_idx    = victim_q;
            end
        end
    end

    // Table and victim pointer update; reset dominates any concurrent write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= '0;
            key_q    <= '0;
            val_q    <= '0;
            victim_q <= '0;
        end else begin
            case (wr_action)
                WrUpdate: begin
                    val_q[wr_idx] <= write_val;
                end
                WrFill: begin
                    valid_q[wr_idx] <= 1'b1;
                    key_q[wr_idx]   <= write_key;
                    val_q[wr_idx]   <= write_val;
                end
                WrEvict: begin
                    valid_q[wr_idx] <= 1'b1;
                    key_q[wr_idx]   <= write_key;
                    val_q[wr_idx]   <= write_val;
                    // DEPTH is a power of two, so natural overflow wraps.
                    victim_q        <= victim_q + IDX_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_target_lut.sv
// Directed bench for branch_target_lut. Stimulus drives the read key and
// pushes the expected read response into a queue; a monitor process pops
// each entry and compares it against the live DUT outputs.
module tb_branch_target_lut;

    logic        clk;
    logic        reset;
    logic        write;
    logic [15:0] write_key;
    logic [15:0] write_val;
    logic [15:0] read_key;
    logic [15:0] read_val;
    logic        read_valid;

    typedef struct {
        logic [15:0] key;
        logic        exp_valid;
        logic [15:0] exp_val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks;
    int   n_fail;

    branch_target_lut #(
        .ADDR_WIDTH (16),
        .DEPTH      (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .write      (write),
        .write_key  (write_key),
        .write_val  (write_val),
        .read_key   (read_key),
        .read_val   (read_val),
        .read_valid (read_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare the DUT read port against each queued expectation.
    initial begin
        n_checks = 0;
        n_fail   = 0;
        forever begin
            wait (exp_q.size() != 0);
            mon_e = exp_q.pop_front();
            n_checks++;
            if (read_valid !== mon_e.exp_valid) begin
                n_fail++;
                $display("FAIL %s: key=%h got valid=%b, expected valid=%b",
                         mon_e.name, mon_e.key, read_valid, mon_e.exp_valid);
            end
            if (read_val !== mon_e.exp_val) begin
                n_fail++;
                $display("FAIL %s: key=%h got val=%h, expected val=%h",
                         mon_e.name, mon_e.key, read_val, mon_e.exp_val);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input logic [15:0] key, input logic ev, input logic [15:0] evl,
                         input string name);
        exp_t e;
        read_key = key;
        #1;
        e.key       = key;
        e.exp_valid = ev;
        e.exp_val   = evl;
        e.name      = name;
        exp_q.push_back(e);
        wait (exp_q.size() == 0);
    endtask

    task automatic do_write(input logic [15:0] k, input logic [15:0] v);
        @(negedge clk);
        write     = 1'b1;
        write_key = k;
        write_val = v;
        @(posedge clk);
        #1;
        write = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        write     = 1'b0;
        write_key = '0;
        write_val = '0;
        read_key  = '0;

        // 1. Reset state, no clock edge yet.
        check(16'h0010, 1'b0, 16'h0000, "rst_read_0010");
        check(16'h0000, 1'b0, 16'h0000, "rst_read_key0");
        @(negedge clk);
        reset = 1'b1;
        check(16'h0010, 1'b0, 16'h0000, "post_rst_miss");

        // 2. Insert; same-cycle read sees pre-write contents.
        @(negedge clk);
        write     = 1'b1;
        write_key = 16'h0010;
        write_val = 16'h0040;
        check(16'h0010, 1'b0, 16'h0000, "rdw_same_cycle_miss");
        @(posedge clk);
        #1;
        write = 1'b0;
        check(16'h0010, 1'b1, 16'h0040, "insert_hit");
        check(16'h0011, 1'b0, 16'h0000, "neighbour_miss");

        // 3. Update in place leaves other entries alone.
        do_write(16'h0020, 16'h0077);
        do_write(16'h0010, 16'h0055);
        check(16'h0010, 1'b1, 16'h0055, "update_in_place");
        check(16'h0020, 1'b1, 16'h0077, "update_other_intact");
        do_write(16'h0000, 16'h1234);
        check(16'h0000, 1'b1, 16'h1234, "key_zero_hit");
        check(16'h0010, 1'b1, 16'h0055, "key_zero_no_alias");

        // Clean slate for the replacement test.
        @(negedge clk);
        reset = 1'b0;
        check(16'h0010, 1'b0, 16'h0000, "clean_reset_miss");
        reset = 1'b1;

        // 4. Fill all eight slots, then round-robin replacement.
        for (int i = 0; i < 8; i++) do_write(16'h0100 + 16'(i), 16'h0200 + 16'(i));
        for (int i = 0; i < 8; i++) check(16'h0100 + 16'(i), 1'b1, 16'h0200 + 16'(i), "fill_hit");
        do_write(16'h0108, 16'h0208);
        check(16'h0100, 1'b0, 16'h0000, "evict_entry0");
        check(16'h0108, 1'b1, 16'h0208, "evict_new0_hit");
        check(16'h0101, 1'b1, 16'h0201, "evict_entry1_kept");
        do_write(16'h0109, 16'h0209);
        check(16'h0101, 1'b0, 16'h0000, "evict_entry1");
        check(16'h0109, 1'b1, 16'h0209, "evict_new1_hit");
        for (int i = 10; i < 16; i++) do_write(16'h0100 + 16'(i), 16'h0200 + 16'(i));
        check(16'h0107, 1'b0, 16'h0000, "evict_entry7");
        check(16'h010f, 1'b1, 16'h020f, "evict_new7_hit");
        check(16'h0108, 1'b1, 16'h0208, "pre_wrap_entry0_kept");
        do_write(16'h0110, 16'h0210);
        check(16'h0108, 1'b0, 16'h0000, "wrap_evicts_entry0");
        check(16'h0110, 1'b1, 16'h0210, "wrap_new_hit");
        check(16'h0109, 1'b1, 16'h0209, "wrap_entry1_kept");

        // 5. Async reset between edges, with a write pending.
        @(negedge clk);
        write     = 1'b1;
        write_key = 16'h0300;
        write_val = 16'h0abc;
        #1;
        reset = 1'b0;
        check(16'h0110, 1'b0, 16'h0000, "async_rst_drop");
        @(posedge clk);
        #1;
        write = 1'b0;
        #1;
        reset = 1'b1;
        check(16'h0300, 1'b0, 16'h0000, "write_during_reset_dropped");
        check(16'h0110, 1'b0, 16'h0000, "after_rst_still_miss");

        // 6. write=0 with live bus data changes nothing.
        do_write(16'h0401, 16'h0111);
        @(negedge clk);
        write_key = 16'h0401;
        write_val = 16'h0999;
        @(negedge clk);
        write_key = 16'h0402;
        write_val = 16'h0222;
        repeat (3) @(posedge clk);
        #1;
        check(16'h0401, 1'b1, 16'h0111, "idle_bus_no_update");
        check(16'h0402, 1'b0, 16'h0000, "idle_bus_no_insert");

        wait (exp_q.size() == 0);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
